spi_slave_mem_ctrl: RTL and testbench

SPI slave front end that terminates the serial link driven by the SPI master (`baby`): it conditions `sclk`, `cs_n` and `mosi`, decodes an address/command byte and moves one data byte to or from an external synchronous byte memory. It sits directly downstream of the master. It consumes the master's MOSI/SCLK/CS and produces the MISO the master conditions and shifts in.

---
 rtl/spi_slave_mem_ctrl_if.sv | 43 ++++
 rtl/spi_slave_mem_ctrl.sv | 217 +++++++++++++++++++++
 tb/tb_spi_slave_mem_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_mem_ctrl_if.sv
// Bundle of the SPI pad signals and the byte-memory port seen by spi_slave_mem_ctrl.
// The slave modport is the controller's view; the master modport is the view of whatever drives it.
interface spi_slave_mem_ctrl_if #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
);
    logic              sclk;
    logic              cs_n;
    logic              mosi;
    logic              miso;
    logic              miso_oe;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic              busy;

    modport slave (
        input  sclk,
        input  cs_n,
        input  mosi,
        input  mem_rdata,
        output miso,
        output miso_oe,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output busy
    );

    modport master (
        output sclk,
        output cs_n,
        output mosi,
        output mem_rdata,
        input  miso,
        input  miso_oe,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  busy
    );
endinterface

// File: rtl/spi_slave_mem_ctrl.sv
// SPI mode-0 slave: conditions the asynchronous pads, decodes a {addr, rw} command byte
// and moves one data byte to or from an external synchronous byte memory.
module spi_slave_mem_ctrl #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    spi_slave_mem_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_CMD      = 3'd1,
        ST_RD_FETCH = 3'd2,
        ST_RD_LOAD  = 3'd3,
        ST_RD_SHIFT = 3'd4,
        ST_WR_SHIFT = 3'd5,
        ST_WR_MEM   = 3'd6,
        ST_DONE     = 3'd7
    } state_e;

    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_dly_q, sclk_dly_d;
    logic                   cs_dly_q, cs_dly_d;

    logic sclk_rise_s;
    logic sclk_fall_s;
    logic cs_rise_s;
    logic cs_fall_s;
    logic mosi_bit_s;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_we_q, mem_we_d;
    logic              miso_q, miso_d;
    logic              miso_oe_q, miso_oe_d;
    logic              busy_q, busy_d;

    logic [DATA_W-1:0] shift_in_s;
    logic [3:0]        cnt_inc_s;

    // Next values of the pad synchronizers and the edge-detect delay flops
    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], bus.sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], bus.cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], bus.mosi};
        sclk_dly_d  = sclk_sync_q[SYNC_STAGES-1];
        cs_dly_d    = cs_sync_q[SYNC_STAGES-1];
    end

    // Pad synchronizer and edge-detect registers; cs_n resets to its inactive level
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sclk_sync_q <= {SYNC_STAGES{1'b0}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= {SYNC_STAGES{1'b0}};
            sclk_dly_q  <= 1'b0;
            cs_dly_q    <= 1'b1;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_dly_q  <= sclk_dly_d;
            cs_dly_q    <= cs_dly_d;
        end
    end

    assign sclk_rise_s = sclk_sync_q[SYNC_STAGES-1] & ~sclk_dly_q;
    assign sclk_fall_s = ~sclk_sync_q[SYNC_STAGES-1] & sclk_dly_q;
    assign cs_rise_s   = cs_sync_q[SYNC_STAGES-1] & ~cs_dly_q;
    assign cs_fall_s   = ~cs_sync_q[SYNC_STAGES-1] & cs_dly_q;
    assign mosi_bit_s  = mosi_sync_q[SYNC_STAGES-1];

    // mosi travels through the same synchronizer depth as sclk, so it is aligned with the rise pulse
    assign shift_in_s = {shift_q[DATA_W-2:0], mosi_bit_s};
    assign cnt_inc_s  = (cnt_q == 4'd15) ? cnt_q : (cnt_q + 4'd1);

    // Frame sequencer: next state, counters, shift register and output values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        shift_d     = shift_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        miso_d      = miso_q;
        miso_oe_d   = miso_oe_q;
        busy_d      = ~cs_sync_q[SYNC_STAGES-1];
        // The strobe follows the state alone, so a chip-select rise in WR_MEM cannot cancel it
        mem_we_d    = (state_q == ST_WR_MEM);

        if (cs_rise_s) begin
            state_d   = ST_IDLE;
            miso_d    = 1'b0;
            miso_oe_d = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    if (cs_fall_s) begin
                        state_d = ST_CMD;
                        cnt_d   = 4'd0;
                        shift_d = {DATA_W{1'b0}};
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_CMD: begin
                    if (sclk_rise_s) begin
                        shift_d = shift_in_s;
                        cnt_d   = cnt_inc_s;
                        if (cnt_q == 4'd7) begin
                            mem_addr_d = shift_in_s[DATA_W-1 -: ADDR_W];
                            state_d    = shift_in_s[0] ? ST_RD_FETCH : ST_WR_SHIFT;
                        end else begin
                            state_d = ST_CMD;
                        end
                    end else begin
                        state_d = ST_CMD;
                    end
                end
                ST_RD_FETCH: begin
                    state_d = ST_RD_LOAD;
                end
                ST_RD_LOAD: begin
                    shift_d = bus.mem_rdata;
                    cnt_d   = 4'd0;
                    state_d = ST_RD_SHIFT;
                end
                ST_RD_SHIFT: begin
                    // Falls 1-8 present the byte; the next fall closes the last bit cell
                    if (sclk_fall_s) begin
                        if (cnt_q == 4'd8) begin
                            miso_d    = 1'b0;
                            miso_oe_d = 1'b0;
                            state_d   = ST_DONE;
                        end else begin
                            miso_d    = shift_q[DATA_W-1];
                            miso_oe_d = 1'b1;
                            shift_d   = {shift_q[DATA_W-2:0], 1'b0};
                            cnt_d     = cnt_inc_s;
                        end
                    end else begin
                        state_d = ST_RD_SHIFT;
                    end
                end
                ST_WR_SHIFT: begin
                    if (sclk_rise_s) begin
                        shift_d = shift_in_s;
                        cnt_d   = cnt_inc_s;
                        if (cnt_q == 4'd15) begin
                            mem_wdata_d = shift_in_s;
                            state_d     = ST_WR_MEM;
                        end else begin
                            state_d = ST_WR_SHIFT;
                        end
                    end else begin
                        state_d = ST_WR_SHIFT;
                    end
                end
                ST_WR_MEM: begin
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    state_d   = ST_DONE;
                end
                default: begin
                    miso_d    = 1'b0;
                    miso_oe_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            endcase
        end
    end

    // Sequencer state and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            shift_q     <= {DATA_W{1'b0}};
            mem_addr_q  <= {ADDR_W{1'b0}};
            mem_wdata_q <= {DATA_W{1'b0}};
            mem_we_q    <= 1'b0;
            miso_q      <= 1'b0;
            miso_oe_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            shift_q     <= shift_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            miso_q      <= miso_d;
            miso_oe_q   <= miso_oe_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.miso      = miso_q;
    assign bus.miso_oe   = miso_oe_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_spi_slave_mem_ctrl.sv
// Bench for spi_slave_mem_ctrl: directed frame table, reset cases and random frames
// scored against a byte-array model of the memory contents.
module tb_spi_slave_mem_ctrl;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    spi_slave_mem_ctrl_if #(.ADDR_W(7), .DATA_W(8)) bus ();

    spi_slave_mem_ctrl #(.ADDR_W(7), .DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic [6:0] addr;
        logic       rw;
        logic [7:0] wdata;
        int         nbits;
        int         extra;
        int         exp_we;
        logic [7:0] exp_rd;
    } vec_t;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] mem [128];
    logic [7:0] ref_mem [128];
    logic       mem_ready   = 1'b0;
    int         we_cnt      = 0;
    logic [6:0] we_addr     = 7'h00;
    logic [7:0] we_data     = 8'h00;

    function automatic logic [7:0] init_val(input int i);
        return 8'(i * 3) ^ 8'h5A;
    endfunction

    // External synchronous byte memory: read data follows the address by one clock
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 128; i++) mem[i] <= init_val(i);
        end else if (bus.mem_we === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
        end
        bus.mem_rdata <= mem[bus.mem_addr];
    end

    // Write-strobe monitor
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.mem_addr;
            we_data <= bus.mem_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_miso"},      32'(bus.miso),      32'd0);
        check({tag, "_miso_oe"},   32'(bus.miso_oe),   32'd0);
        check({tag, "_mem_we"},    32'(bus.mem_we),    32'd0);
        check({tag, "_mem_addr"},  32'(bus.mem_addr),  32'd0);
        check({tag, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
        check({tag, "_busy"},      32'(bus.busy),      32'd0);
    endtask

    // Drives one mode-0 frame; rst_bit >= 0 pulls reset_n low while that bit is on the wire
    task automatic spi_frame(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                             input int nbits, input int extra, input int half, input int rst_bit,
                             output logic [7:0] rd, output int oe_err);
        logic [15:0] frame;
        frame  = {a, rw, wd};
        rd     = 8'h00;
        oe_err = 0;
        bus.cs_n = 1'b0;
        repeat (half) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.mosi = frame[15-i];
            repeat (half) @(negedge clk);
            if (i == 4) check("busy_mid", 32'(bus.busy), 32'd1);
            if (rw && i >= 8) begin
                rd = {rd[6:0], bus.miso};
                if (bus.miso_oe !== 1'b1) oe_err++;
            end else if (bus.miso_oe !== 1'b0) begin
                oe_err++;
            end
            if (i == rst_bit) begin
                check("rst_oe_before", 32'(bus.miso_oe), 32'd1);
                reset_n = 1'b0;
                #1;
                check_reset_outputs("rst_mid");
                @(negedge clk);
                bus.cs_n = 1'b1;
                bus.sclk = 1'b0;
                repeat (3) @(negedge clk);
                reset_n = 1'b1;
                repeat (6) @(negedge clk);
                return;
            end
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
        end
        for (int e = 0; e < extra; e++) begin
            bus.mosi = 1'($urandom);
            repeat (half) @(negedge clk);
            bus.sclk = 1'b1;
            repeat (half) @(negedge clk);
            bus.sclk = 1'b0;
        end
        repeat (half) @(negedge clk);
        bus.cs_n = 1'b1;
        repeat (half + 3) @(negedge clk);
    endtask

    task automatic run_frame(input string name, input logic [6:0] a, input logic rw,
                             input logic [7:0] wd, input int nbits, input int extra, input int half,
                             input int exp_we, input logic [7:0] exp_rd);
        logic [7:0] rd;
        int         oe_err;
        int         we0;
        we0 = we_cnt;
        spi_frame(a, rw, wd, nbits, extra, half, -1, rd, oe_err);
        check({name, "_we_count"}, 32'(we_cnt - we0), 32'(exp_we));
        if (exp_we != 0) begin
            check({name, "_we_addr"}, 32'(we_addr), 32'(a));
            check({name, "_we_data"}, 32'(we_data), 32'(wd));
        end
        if (rw && nbits == 16) check({name, "_rdata"}, 32'(rd), 32'(exp_rd));
        check({name, "_oe_window"}, 32'(oe_err), 32'd0);
        if (nbits >= 8) check({name, "_mem_addr"}, 32'(bus.mem_addr), 32'(a));
        check({name, "_oe_after"},   32'(bus.miso_oe), 32'd0);
        check({name, "_busy_after"}, 32'(bus.busy),    32'd0);
    endtask

    // Memory-content model: only a complete write frame changes a byte
    function automatic void model_update(input logic [6:0] a, input logic rw, input logic [7:0] wd,
                                         input int nbits);
        if (!rw && nbits >= 16) ref_mem[a] = wd;
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t       tbl [6];
        logic [7:0] rd;
        int         oe_err;
        int         we0;

        tbl[0] = '{addr: 7'h12, rw: 1'b0, wdata: 8'hA5, nbits: 16, extra: 0, exp_we: 1, exp_rd: 8'h00};
        tbl[1] = '{addr: 7'h12, rw: 1'b1, wdata: 8'h00, nbits: 16, extra: 0, exp_we: 0, exp_rd: 8'hA5};
        tbl[2] = '{addr: 7'h12, rw: 1'b0, wdata: 8'h5A, nbits: 12, extra: 0, exp_we: 0, exp_rd: 8'h00};
        tbl[3] = '{addr: 7'h12, rw: 1'b1, wdata: 8'h00, nbits: 16, extra: 0, exp_we: 0, exp_rd: 8'hA5};
        tbl[4] = '{addr: 7'h7F, rw: 1'b0, wdata: 8'h3C, nbits: 16, extra: 4, exp_we: 1, exp_rd: 8'h00};
        tbl[5] = '{addr: 7'h7F, rw: 1'b1, wdata: 8'h00, nbits: 16, extra: 0, exp_we: 0, exp_rd: 8'h3C};

        for (int i = 0; i < 128; i++) ref_mem[i] = init_val(i);

        // Reset held with the pads toggling
        reset_n  = 1'b0;
        bus.sclk = 1'b0;
        bus.cs_n = 1'b1;
        bus.mosi = 1'b0;
        repeat (20) begin
            @(negedge clk);
            bus.sclk = 1'($urandom);
            bus.cs_n = 1'($urandom);
            bus.mosi = 1'($urandom);
        end
        check_reset_outputs("in_reset");
        bus.sclk  = 1'b0;
        bus.cs_n  = 1'b1;
        bus.mosi  = 1'b0;
        mem_ready = 1'b1;
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (10) @(negedge clk);
        check_reset_outputs("post_reset");

        // Directed frame table
        for (int k = 0; k < 6; k++) begin
            run_frame($sformatf("tbl%0d", k), tbl[k].addr, tbl[k].rw, tbl[k].wdata,
                      tbl[k].nbits, tbl[k].extra, 4, tbl[k].exp_we, tbl[k].exp_rd);
            model_update(tbl[k].addr, tbl[k].rw, tbl[k].wdata, tbl[k].nbits);
        end

        // Asynchronous reset while bit 11 of a read is on the wire, then a normal read
        we0 = we_cnt;
        spi_frame(7'h7F, 1'b1, 8'h00, 16, 0, 4, 10, rd, oe_err);
        check("rst_no_write", 32'(we_cnt - we0), 32'd0);
        check("rst_oe_window", 32'(oe_err), 32'd0);
        run_frame("after_rst", 7'h7F, 1'b1, 8'h00, 16, 0, 4, 0, ref_mem[7'h7F]);

        // Random frames against the memory model, some aborted early
        for (int n = 0; n < 30; n++) begin
            logic [6:0] a;
            logic       rw;
            logic [7:0] wd;
            int         nbits;
            int         half;
            a     = 7'($urandom_range(0, 15));
            rw    = 1'($urandom);
            wd    = 8'($urandom);
            nbits = ($urandom_range(0, 4) == 0) ? int'($urandom_range(9, 15)) : 16;
            half  = int'($urandom_range(4, 6));
            run_frame($sformatf("rnd%0d", n), a, rw, wd, nbits, int'($urandom_range(0, 3)), half,
                      (!rw && nbits >= 16) ? 1 : 0, ref_mem[a]);
            model_update(a, rw, wd, nbits);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
